// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART CSR stream bridge.
// Holds the bridge FSM states, the UART register offsets and the divisor helper.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    TX_WR  = 3'd2,
    RX_RD  = 3'd3,
    RX_CAP = 3'd4
  } state_t;

  localparam logic [1:0] REG_RXTX = 2'd0;
  localparam logic [1:0] REG_DIV  = 2'd1;

  // Baud divisor for a 16x oversampling UART, truncated to the 16-bit register.
  function automatic logic [15:0] calc_divisor(input int unsigned clk_freq,
                                               input int unsigned baud);
    return 16'(clk_freq / (32'd16 * baud));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head output.
// A push and pop in the same cycle are both honoured, even when full or empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == {(AW+1){1'b0}});
  assign head  = mem_r[rd_ptr_r];

  // Qualify requests: a full FIFO accepts a push only alongside a pop, and vice versa when empty.
  always_comb begin
    do_push_s = push & (~full | pop);
    do_pop_s  = pop & (~empty | push);
  end

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (do_push_s && !do_pop_s) begin
        count_r <= count_r + (AW+1)'(1);
      end else if (do_pop_s && !do_push_s) begin
        count_r <= count_r - (AW+1)'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/uart_stream_bridge.sv
// Bridges byte valid/ready streams onto the UART 14-bit CSR bus.
// Programs the divisor once after reset, then paces TX writes by tx_irq and RX reads by rx_irq.
module uart_stream_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 32'd50_000_000,
  parameter int unsigned BAUD     = 32'd115_200,
  parameter logic [3:0]  CSR_ADDR = 4'h0,
  parameter int          TX_DEPTH = 16,
  parameter int          RX_DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_overrun,
  output logic        init_done,
  output logic [13:0] csr_a,
  output logic        csr_we,
  output logic [31:0] csr_di,
  input  logic [31:0] csr_do,
  input  logic        rx_irq,
  input  logic        tx_irq
);

  localparam logic [15:0] DIVISOR = calc_divisor(CLK_FREQ, BAUD);

  state_t      state_r;
  logic        tx_busy_r;
  logic        rx_pend_r;
  logic        init_done_r;
  logic [13:0] csr_a_r;
  logic        csr_we_r;
  logic [31:0] csr_di_r;
  logic        rx_overrun_r;

  logic        tx_push_s;
  logic        tx_pop_s;
  logic [7:0]  tx_head_s;
  logic        tx_full_s;
  logic        tx_empty_s;
  logic        rx_push_s;
  logic        rx_pop_s;
  logic [7:0]  rx_head_s;
  logic        rx_full_s;
  logic        rx_empty_s;
  logic        rx_space_s;
  logic        rx_start_s;
  logic [23:0] unused_csr_do_s;

  assign unused_csr_do_s = csr_do[31:8];

  assign tx_ready   = init_done_r & ~tx_full_s;
  assign rx_valid   = ~rx_empty_s;
  assign rx_data    = rx_head_s;
  assign init_done  = init_done_r;
  assign csr_a      = csr_a_r;
  assign csr_we     = csr_we_r;
  assign csr_di     = csr_di_r;
  assign rx_overrun = rx_overrun_r;

  // Stream handshakes and FSM launch conditions; RX service outranks TX.
  always_comb begin
    tx_push_s  = tx_valid & tx_ready;
    rx_pop_s   = rx_valid & rx_ready;
    rx_space_s = ~rx_full_s | rx_pop_s;
    rx_start_s = (state_r == IDLE) & rx_pend_r;
    tx_pop_s   = (state_r == IDLE) & ~rx_pend_r & ~tx_busy_r & ~tx_empty_s;
    rx_push_s  = (state_r == RX_CAP) & rx_space_s;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (tx_push_s),
    .pop   (tx_pop_s),
    .din   (tx_data),
    .head  (tx_head_s),
    .full  (tx_full_s),
    .empty (tx_empty_s)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (rx_push_s),
    .pop   (rx_pop_s),
    .din   (csr_do[7:0]),
    .head  (rx_head_s),
    .full  (rx_full_s),
    .empty (rx_empty_s)
  );

  // Bridge FSM: CSR outputs are registered on the edge that enters the state they belong to.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r      <= INIT;
      tx_busy_r    <= 1'b0;
      rx_pend_r    <= 1'b0;
      init_done_r  <= 1'b0;
      csr_a_r      <= {CSR_ADDR, 10'h000};
      csr_we_r     <= 1'b0;
      csr_di_r     <= 32'h0000_0000;
      rx_overrun_r <= 1'b0;
    end else begin
      csr_we_r     <= 1'b0;
      rx_overrun_r <= 1'b0;
      // A new IRQ on the clearing edge keeps the flag set.
      rx_pend_r    <= rx_irq | (rx_pend_r & ~rx_start_s);
      tx_busy_r    <= tx_pop_s | (tx_busy_r & ~tx_irq);
      case (state_r)
        INIT: begin
          csr_a_r  <= {CSR_ADDR, 8'h00, REG_DIV};
          csr_di_r <= {16'h0000, DIVISOR};
          csr_we_r <= 1'b1;
          state_r  <= IDLE;
        end
        IDLE: begin
          init_done_r <= 1'b1;
          if (rx_pend_r) begin
            csr_a_r <= {CSR_ADDR, 8'h00, REG_RXTX};
            state_r <= RX_RD;
          end else if (tx_pop_s) begin
            csr_a_r  <= {CSR_ADDR, 8'h00, REG_RXTX};
            csr_di_r <= {24'h00_0000, tx_head_s};
            csr_we_r <= 1'b1;
            state_r  <= TX_WR;
          end else begin
            state_r <= IDLE;
          end
        end
        TX_WR: begin
          state_r <= IDLE;
        end
        RX_RD: begin
          state_r <= RX_CAP;
        end
        RX_CAP: begin
          rx_overrun_r <= ~rx_space_s;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Directed self-checking bench for uart_stream_bridge with a tiny UART CSR read model.
module tb_uart_stream_bridge;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        rx_overrun;
  logic        init_done;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        rx_irq = 1'b0;
  logic        tx_irq = 1'b0;

  logic [7:0]  uart_byte = 8'h00;
  logic [13:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          ovr_cnt = 0;
  int          n_cmp = 0;
  int          n_mis = 0;

  uart_stream_bridge dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_overrun (rx_overrun),
    .init_done  (init_done),
    .csr_a      (csr_a),
    .csr_we     (csr_we),
    .csr_di     (csr_di),
    .csr_do     (csr_do),
    .rx_irq     (rx_irq),
    .tx_irq     (tx_irq)
  );

  always #5 sys_clk = ~sys_clk;

  // UART read port: data register returns one cycle after reg 0 is addressed for read.
  always @(posedge sys_clk) begin
    csr_do <= (csr_a[1:0] == 2'd0 && !csr_we) ? {24'h0, uart_byte} : 32'hDEAD_BEEF;
  end

  // Bus monitor for writes and overrun pulses.
  always @(negedge sys_clk) begin
    if (csr_we) begin
      wr_a.push_back(csr_a);
      wr_d.push_back(csr_di);
    end
    if (rx_overrun) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pulse_rx_irq();
    rx_irq = 1'b1;
    tick();
    rx_irq = 1'b0;
  endtask

  task automatic pulse_tx_irq();
    tx_irq = 1'b1;
    tick();
    tx_irq = 1'b0;
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    // Reset values
    tick(2);
    check("rst_csr_we", 32'(csr_we), 32'd0);
    check("rst_csr_a", 32'(csr_a), 32'h0);
    check("rst_csr_di", csr_di, 32'h0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_overrun", 32'(rx_overrun), 32'd0);

    // Init: single divisor write of 27 to reg 1
    sys_rst_n = 1'b1;
    tick();
    check("init_we", 32'(csr_we), 32'd1);
    check("init_addr", 32'(csr_a), 32'h001);
    check("init_div", csr_di, 32'd27);
    check("init_done_early", 32'(init_done), 32'd0);
    check("init_tx_ready_early", 32'(tx_ready), 32'd0);
    tick();
    check("init_we_off", 32'(csr_we), 32'd0);
    check("init_done", 32'(init_done), 32'd1);
    check("init_tx_ready", 32'(tx_ready), 32'd1);
    tick(3);
    check("init_wr_count", 32'(wr_a.size()), 32'd1);
    wr_a.delete();
    wr_d.delete();

    // TX pacing: three bytes, one write per tx_irq
    tx_valid = 1'b1;
    tx_data  = 8'h41;
    tick();
    check("tx_lat_we0", 32'(csr_we), 32'd0);
    tx_data = 8'h42;
    tick();
    check("tx_lat_we1", 32'(csr_we), 32'd1);
    check("tx_first_di", csr_di, 32'h41);
    tx_data = 8'h43;
    tick();
    tx_valid = 1'b0;
    tick(8);
    check("tx_paced_cnt1", 32'(wr_a.size()), 32'd1);
    pulse_tx_irq();
    tick(8);
    check("tx_paced_cnt2", 32'(wr_a.size()), 32'd2);
    pulse_tx_irq();
    tick(8);
    check("tx_paced_cnt3", 32'(wr_a.size()), 32'd3);
    if (wr_a.size() == 3) begin
      check("tx_wr0", wr_d[0], 32'h41);
      check("tx_wr1", wr_d[1], 32'h42);
      check("tx_wr2", wr_d[2], 32'h43);
      check("tx_wr2_addr", 32'(wr_a[2]), 32'h000);
    end
    pulse_tx_irq();
    tick(3);
    wr_a.delete();
    wr_d.delete();

    // RX path: 4-cycle latency, data held while not ready
    uart_byte = 8'h5A;
    pulse_rx_irq();
    tick(2);
    check("rx_lat_early", 32'(rx_valid), 32'd0);
    tick();
    check("rx_lat_valid", 32'(rx_valid), 32'd1);
    check("rx_data", 32'(rx_data), 32'h5A);
    uart_byte = 8'hEE;
    tick(5);
    check("rx_hold_valid", 32'(rx_valid), 32'd1);
    check("rx_hold_data", 32'(rx_data), 32'h5A);
    pop_rx();
    check("rx_popped", 32'(rx_valid), 32'd0);

    // Priority: rx_irq and tx byte arrive together, read goes first
    uart_byte = 8'h77;
    tx_valid  = 1'b1;
    tx_data   = 8'h55;
    rx_irq    = 1'b1;
    tick();
    tx_valid = 1'b0;
    rx_irq   = 1'b0;
    tick();
    check("prio_we_e1", 32'(csr_we), 32'd0);
    tick();
    check("prio_we_e2", 32'(csr_we), 32'd0);
    tick();
    check("prio_we_e3", 32'(csr_we), 32'd0);
    check("prio_rx_valid", 32'(rx_valid), 32'd1);
    check("prio_rx_data", 32'(rx_data), 32'h77);
    tick();
    check("prio_tx_we", 32'(csr_we), 32'd1);
    check("prio_tx_di", csr_di, 32'h55);
    pulse_tx_irq();
    pop_rx();
    tick(3);

    // Back-to-back rx_irq: the set on the clearing edge must win
    uart_byte = 8'h33;
    rx_irq = 1'b1;
    tick(2);
    rx_irq = 1'b0;
    tick(10);
    check("setwin_d0", 32'(rx_data), 32'h33);
    pop_rx();
    check("setwin_v1", 32'(rx_valid), 32'd1);
    check("setwin_d1", 32'(rx_data), 32'h33);
    pop_rx();
    check("setwin_empty", 32'(rx_valid), 32'd0);

    // Overrun: 17 bytes into a 16-deep FIFO
    ovr_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      uart_byte = i[7:0];
      pulse_rx_irq();
      tick(6);
      if (i == 15) check("ovr_before_17th", 32'(ovr_cnt), 32'd0);
    end
    check("ovr_count", 32'(ovr_cnt), 32'd1);

    // Full FIFO with a pop on the capture edge still accepts the byte
    uart_byte = 8'h20;
    rx_irq = 1'b1;
    tick();
    rx_irq = 1'b0;
    tick(2);
    check("full_pop_d0", 32'(rx_data), 32'h00);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick(2);
    check("full_pop_no_ovr", 32'(ovr_cnt), 32'd1);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("ovr_order_%0d", i), 32'(rx_data), 32'(i));
      pop_rx();
    end
    check("full_pop_last", 32'(rx_data), 32'h20);
    pop_rx();
    check("ovr_drained", 32'(rx_valid), 32'd0);

    // Reset mid-TX: one byte in flight, five queued
    wr_a.delete();
    wr_d.delete();
    tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_data = 8'h60 + i[7:0];
      tick();
    end
    tx_valid = 1'b0;
    tick(3);
    check("mid_wr_count", 32'(wr_a.size()), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(csr_we), 32'd0);
    check("mid_rst_a", 32'(csr_a), 32'h0);
    check("mid_rst_di", csr_di, 32'h0);
    check("mid_rst_init", 32'(init_done), 32'd0);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd0);
    tick(2);
    wr_a.delete();
    wr_d.delete();
    sys_rst_n = 1'b1;
    tick(4);
    pulse_tx_irq();
    tick(4);
    pulse_tx_irq();
    tick(10);
    check("post_rst_wr_count", 32'(wr_a.size()), 32'd1);
    if (wr_a.size() >= 1) begin
      check("post_rst_addr", 32'(wr_a[0]), 32'h001);
      check("post_rst_div", wr_d[0], 32'd27);
    end
    check("post_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("post_rst_rx_valid", 32'(rx_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
